// File: rtl/dsp_cfg_pkg.sv
// Shared types and constants for the CORDIC converter run-time configuration scheduler.
package dsp_cfg_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StRamp,
        StSweep
    } state_e;

    localparam logic [31:0] GAIN_UNITY = 32'h4000_0000;

    localparam logic [1:0] OSEL_DOWNSAMPLED  = 2'b00;
    localparam logic [1:0] OSEL_UPSAMPLED    = 2'b01;
    localparam logic [1:0] OSEL_DOWNCONVERTED = 2'b10;
    localparam logic [1:0] OSEL_UPCONVERTED  = 2'b11;

endpackage

// File: rtl/gain_ramp_step.sv
// One gain channel of the ramp: next live value one step toward target, plus a reached flag.
module gain_ramp_step
    import dsp_cfg_pkg::*;
#(
    parameter int unsigned GW = 32
) (
    input  logic [GW-1:0] live,
    input  logic [GW-1:0] target,
    input  logic [GW-1:0] step,
    output logic [GW-1:0] next,
    output logic          reached
);

    logic [GW:0] live_x;
    logic [GW:0] target_x;
    logic [GW:0] step_x;
    logic [GW:0] diff;
    logic [GW:0] moved;
    logic [GW:0] next_x;

    // Guard bit keeps live +/- step from wrapping; the clamp to target bounds the result anyway.
    always_comb begin
        live_x   = {1'b0, live};
        target_x = {1'b0, target};
        step_x   = {1'b0, step};
        if (target_x >= live_x) begin
            diff  = target_x - live_x;
            moved = live_x + step_x;
        end else begin
            diff  = live_x - target_x;
            moved = live_x - step_x;
        end
        next_x  = (diff <= step_x) ? target_x : moved;
        next    = next_x[GW-1:0];
        reached = (next_x == target_x);
    end

endmodule

// File: rtl/dsp_cfg_scheduler.sv
// Shadow/commit scheduler for converter NCO, mixer and gain settings; applies only on ce_down,
// ramps gains linearly and runs a linear sweep of the downconversion phase increment.
module dsp_cfg_scheduler
    import dsp_cfg_pkg::*;
#(
    parameter int unsigned    PW       = 19,
    parameter int unsigned    GW       = 32,
    parameter int unsigned    CW       = 16,
    parameter logic [GW-1:0] GAIN_RST = GAIN_UNITY
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic [PW-1:0] cfg_phase_inc_nco,
    input  logic [PW-1:0] cfg_phase_inc_down,
    input  logic [GW-1:0] cfg_gain1,
    input  logic [GW-1:0] cfg_gain2,
    input  logic [GW-1:0] cfg_gain_step,
    input  logic          cfg_input_select,
    input  logic [1:0]    cfg_output_select,
    input  logic [PW-1:0] cfg_sweep_step,
    input  logic [CW-1:0] cfg_sweep_count,
    input  logic          commit,
    input  logic          sweep_start,
    input  logic          abort,
    input  logic          ce_down,
    output logic [PW-1:0] phase_inc_nco,
    output logic [PW-1:0] phase_inc_down,
    output logic [GW-1:0] gain1,
    output logic [GW-1:0] gain2,
    output logic          input_select,
    output logic [1:0]    output_select,
    output logic          busy,
    output logic          sweep_done,
    output logic          cmd_err
);

    state_e state_q, state_d;

    logic [PW-1:0] sh_nco_q, sh_nco_d;
    logic [PW-1:0] sh_down_q, sh_down_d;
    logic [GW-1:0] sh_gain1_q, sh_gain1_d;
    logic [GW-1:0] sh_gain2_q, sh_gain2_d;
    logic [GW-1:0] sh_step_q, sh_step_d;
    logic          sh_isel_q, sh_isel_d;
    logic [1:0]    sh_osel_q, sh_osel_d;

    logic [PW-1:0] sw_step_q, sw_step_d;
    logic [CW-1:0] sw_cnt_q, sw_cnt_d;

    logic [PW-1:0] nco_q, nco_d;
    logic [PW-1:0] down_q, down_d;
    logic [GW-1:0] gain1_q, gain1_d;
    logic [GW-1:0] gain2_q, gain2_d;
    logic          isel_q, isel_d;
    logic [1:0]    osel_q, osel_d;
    logic          busy_q;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [GW-1:0] gain1_next, gain2_next;
    logic          gain1_reached, gain2_reached;

    gain_ramp_step #(
        .GW(GW)
    ) u_ramp1 (
        .live    (gain1_q),
        .target  (sh_gain1_q),
        .step    (sh_step_q),
        .next    (gain1_next),
        .reached (gain1_reached)
    );

    gain_ramp_step #(
        .GW(GW)
    ) u_ramp2 (
        .live    (gain2_q),
        .target  (sh_gain2_q),
        .step    (sh_step_q),
        .next    (gain2_next),
        .reached (gain2_reached)
    );

    always_comb begin
        state_d    = state_q;
        sh_nco_d   = sh_nco_q;
        sh_down_d  = sh_down_q;
        sh_gain1_d = sh_gain1_q;
        sh_gain2_d = sh_gain2_q;
        sh_step_d  = sh_step_q;
        sh_isel_d  = sh_isel_q;
        sh_osel_d  = sh_osel_q;
        sw_step_d  = sw_step_q;
        sw_cnt_d   = sw_cnt_q;
        nco_d      = nco_q;
        down_d     = down_q;
        gain1_d    = gain1_q;
        gain2_d    = gain2_q;
        isel_d     = isel_q;
        osel_d     = osel_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (commit) begin
                        sh_nco_d   = cfg_phase_inc_nco;
                        sh_down_d  = cfg_phase_inc_down;
                        sh_gain1_d = cfg_gain1;
                        sh_gain2_d = cfg_gain2;
                        sh_step_d  = cfg_gain_step;
                        sh_isel_d  = cfg_input_select;
                        sh_osel_d  = cfg_output_select;
                        err_d      = sweep_start;
                        state_d    = StArmed;
                    end else if (sweep_start) begin
                        sw_step_d = cfg_sweep_step;
                        sw_cnt_d  = cfg_sweep_count;
                        if (cfg_sweep_count == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = StSweep;
                        end
                    end
                end
                StArmed: begin
                    err_d = sweep_start;
                    // A strobe coinciding with a recapture is skipped so the new shadow is whole.
                    if (commit) begin
                        sh_nco_d   = cfg_phase_inc_nco;
                        sh_down_d  = cfg_phase_inc_down;
                        sh_gain1_d = cfg_gain1;
                        sh_gain2_d = cfg_gain2;
                        sh_step_d  = cfg_gain_step;
                        sh_isel_d  = cfg_input_select;
                        sh_osel_d  = cfg_output_select;
                    end else if (ce_down) begin
                        nco_d  = sh_nco_q;
                        down_d = sh_down_q;
                        isel_d = sh_isel_q;
                        osel_d = sh_osel_q;
                        if (sh_step_q == '0) begin
                            gain1_d = sh_gain1_q;
                            gain2_d = sh_gain2_q;
                            state_d = StIdle;
                        end else begin
                            state_d = StRamp;
                        end
                    end
                end
                StRamp: begin
                    err_d = commit | sweep_start;
                    if (ce_down) begin
                        gain1_d = gain1_next;
                        gain2_d = gain2_next;
                        if (gain1_reached && gain2_reached) begin
                            state_d = StIdle;
                        end
                    end
                end
                StSweep: begin
                    err_d = commit | sweep_start;
                    if (ce_down) begin
                        down_d   = down_q + sw_step_q;
                        sw_cnt_d = sw_cnt_q - CW'(1);
                        if (sw_cnt_q == CW'(1)) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q    <= StIdle;
            sh_nco_q   <= '0;
            sh_down_q  <= '0;
            sh_gain1_q <= GAIN_RST;
            sh_gain2_q <= GAIN_RST;
            sh_step_q  <= '0;
            sh_isel_q  <= 1'b0;
            sh_osel_q  <= 2'b00;
            sw_step_q  <= '0;
            sw_cnt_q   <= '0;
            nco_q      <= '0;
            down_q     <= '0;
            gain1_q    <= GAIN_RST;
            gain2_q    <= GAIN_RST;
            isel_q     <= 1'b0;
            osel_q     <= 2'b00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_nco_q   <= sh_nco_d;
            sh_down_q  <= sh_down_d;
            sh_gain1_q <= sh_gain1_d;
            sh_gain2_q <= sh_gain2_d;
            sh_step_q  <= sh_step_d;
            sh_isel_q  <= sh_isel_d;
            sh_osel_q  <= sh_osel_d;
            sw_step_q  <= sw_step_d;
            sw_cnt_q   <= sw_cnt_d;
            nco_q      <= nco_d;
            down_q     <= down_d;
            gain1_q    <= gain1_d;
            gain2_q    <= gain2_d;
            isel_q     <= isel_d;
            osel_q     <= osel_d;
            busy_q     <= (state_d != StIdle);
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign phase_inc_nco  = nco_q;
    assign phase_inc_down = down_q;
    assign gain1          = gain1_q;
    assign gain2          = gain2_q;
    assign input_select   = isel_q;
    assign output_select  = osel_q;
    assign busy           = busy_q;
    assign sweep_done     = done_q;
    assign cmd_err        = err_q;

endmodule

// File: tb/tb_dsp_cfg_scheduler.sv
// Scoreboard bench: stimulus pushes the expected output snapshot and cycle of every output change;
// a negedge monitor pops and compares each time any DUT output changes.
module tb_dsp_cfg_scheduler;

    localparam int PW = 19;
    localparam int GW = 32;
    localparam int CW = 16;

    logic          sys_clk = 1'b0;
    logic          rst;
    logic [PW-1:0] cfg_phase_inc_nco, cfg_phase_inc_down, cfg_sweep_step;
    logic [GW-1:0] cfg_gain1, cfg_gain2, cfg_gain_step;
    logic          cfg_input_select;
    logic [1:0]    cfg_output_select;
    logic [CW-1:0] cfg_sweep_count;
    logic          commit, sweep_start, abort, ce_down;
    logic [PW-1:0] phase_inc_nco, phase_inc_down;
    logic [GW-1:0] gain1, gain2;
    logic          input_select;
    logic [1:0]    output_select;
    logic          busy, sweep_done, cmd_err;

    dsp_cfg_scheduler #(
        .PW       (PW),
        .GW       (GW),
        .CW       (CW),
        .GAIN_RST (32'h4000_0000)
    ) dut (
        .sys_clk            (sys_clk),
        .rst                (rst),
        .cfg_phase_inc_nco  (cfg_phase_inc_nco),
        .cfg_phase_inc_down (cfg_phase_inc_down),
        .cfg_gain1          (cfg_gain1),
        .cfg_gain2          (cfg_gain2),
        .cfg_gain_step      (cfg_gain_step),
        .cfg_input_select   (cfg_input_select),
        .cfg_output_select  (cfg_output_select),
        .cfg_sweep_step     (cfg_sweep_step),
        .cfg_sweep_count    (cfg_sweep_count),
        .commit             (commit),
        .sweep_start        (sweep_start),
        .abort              (abort),
        .ce_down            (ce_down),
        .phase_inc_nco      (phase_inc_nco),
        .phase_inc_down     (phase_inc_down),
        .gain1              (gain1),
        .gain2              (gain2),
        .input_select       (input_select),
        .output_select      (output_select),
        .busy               (busy),
        .sweep_done         (sweep_done),
        .cmd_err            (cmd_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [PW-1:0] nco;
        logic [PW-1:0] down;
        logic [GW-1:0] g1;
        logic [GW-1:0] g2;
        logic          isel;
        logic [1:0]    osel;
        logic          busy;
        logic          done;
        logic          err;
    } snap_t;

    typedef struct {
        snap_t s;
        int    cyc;
        string name;
    } exp_t;

    exp_t  expq[$];
    snap_t e;
    snap_t cur, prev;
    exp_t  got_exp;
    bit    have_prev = 1'b0;
    bit    mon_en = 1'b0;
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic string fmt(input snap_t s);
        return $sformatf("nco=%h down=%h g1=%h g2=%h isel=%0d osel=%0d busy=%0d done=%0d err=%0d",
                         s.nco, s.down, s.g1, s.g2, s.isel, s.osel, s.busy, s.done, s.err);
    endfunction

    always @(negedge sys_clk) begin
        if (mon_en) begin
            cur = '{nco: phase_inc_nco, down: phase_inc_down, g1: gain1, g2: gain2,
                    isel: input_select, osel: output_select, busy: busy, done: sweep_done,
                    err: cmd_err};
            if (!have_prev || cur !== prev) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change: cyc=%0d got %s, required no change",
                             cyc, fmt(cur));
                end else begin
                    got_exp = expq.pop_front();
                    if (got_exp.s !== cur || got_exp.cyc != cyc) begin
                        failures++;
                        $display("FAIL %s: got cyc=%0d %s, required cyc=%0d %s", got_exp.name,
                                 cyc, fmt(cur), got_exp.cyc, fmt(got_exp.s));
                    end
                end
            end
            prev      = cur;
            have_prev = 1'b1;
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push(input string name);
        exp_t x;
        x.s    = e;
        x.cyc  = cyc;
        x.name = name;
        expq.push_back(x);
    endtask

    task automatic set_reset_expect();
        e = '{nco: '0, down: '0, g1: 32'h4000_0000, g2: 32'h4000_0000, isel: 1'b0,
              osel: 2'b00, busy: 1'b0, done: 1'b0, err: 1'b0};
    endtask

    initial begin
        rst = 1'b1; commit = 1'b0; sweep_start = 1'b0; abort = 1'b0; ce_down = 1'b0;
        cfg_phase_inc_nco = '0; cfg_phase_inc_down = '0; cfg_gain1 = '0; cfg_gain2 = '0;
        cfg_gain_step = '0; cfg_input_select = 1'b0; cfg_output_select = 2'b00;
        cfg_sweep_step = '0; cfg_sweep_count = '0;
        repeat (3) tick();
        set_reset_expect(); push("reset_state"); mon_en = 1'b1;
        rst = 1'b0;
        repeat (10) tick();

        // Immediate apply: busy spans exactly the five cycles up to the strobe.
        cfg_phase_inc_nco = 19'h00123; cfg_phase_inc_down = 19'h01000;
        cfg_gain1 = 32'h4000_0000; cfg_gain2 = 32'h4000_0000; cfg_gain_step = '0;
        cfg_input_select = 1'b1; cfg_output_select = 2'b10;
        commit = 1'b1; tick(); commit = 1'b0; e.busy = 1'b1; push("commit_busy");
        repeat (4) tick();
        ce_down = 1'b1; tick(); ce_down = 1'b0;
        e.nco = 19'h00123; e.down = 19'h01000; e.isel = 1'b1; e.osel = 2'b10; e.busy = 1'b0;
        push("immediate_apply");
        tick();

        // Gain ramp, gain1 up and gain2 down, with a rejected commit in the middle.
        cfg_phase_inc_nco = 19'h00456; cfg_gain1 = 32'h4000_0A00; cfg_gain2 = 32'h3FFF_F700;
        cfg_gain_step = 32'h0000_0400;
        commit = 1'b1; tick(); commit = 1'b0; e.busy = 1'b1; push("ramp_commit");
        tick();
        ce_down = 1'b1; tick(); ce_down = 1'b0; e.nco = 19'h00456; push("ramp_apply_inc");
        tick();
        ce_down = 1'b1; tick(); ce_down = 1'b0;
        e.g1 = 32'h4000_0400; e.g2 = 32'h3FFF_FC00; push("ramp_step1");
        cfg_gain1 = '0; cfg_gain2 = 32'hFFFF_FFFF;
        commit = 1'b1; tick(); commit = 1'b0; e.err = 1'b1; push("commit_in_ramp");
        tick(); e.err = 1'b0; push("err_one_cycle");
        ce_down = 1'b1; tick(); ce_down = 1'b0;
        e.g1 = 32'h4000_0800; e.g2 = 32'h3FFF_F800; push("ramp_step2");
        ce_down = 1'b1; tick(); ce_down = 1'b0;
        e.g1 = 32'h4000_0A00; e.g2 = 32'h3FFF_F700; e.busy = 1'b0; push("ramp_done");
        ce_down = 1'b1; tick(); ce_down = 1'b0;
        cfg_gain1 = 32'h4000_0A00; cfg_gain2 = 32'h3FFF_F700; cfg_gain_step = '0;

        // Sweep across the wrap point.
        cfg_phase_inc_down = 19'h7FFF0;
        commit = 1'b1; tick(); commit = 1'b0; e.busy = 1'b1; push("base_commit");
        ce_down = 1'b1; tick(); ce_down = 1'b0; e.down = 19'h7FFF0; e.busy = 1'b0;
        push("base_apply");
        cfg_sweep_step = 19'h00020; cfg_sweep_count = 16'd3;
        sweep_start = 1'b1; tick(); sweep_start = 1'b0; e.busy = 1'b1; push("sweep_start");
        ce_down = 1'b1; tick(); ce_down = 1'b0; e.down = 19'h00010; push("sweep_wrap");
        tick();
        ce_down = 1'b1; tick(); ce_down = 1'b0; e.down = 19'h00030; push("sweep_2");
        ce_down = 1'b1; tick(); ce_down = 1'b0;
        e.down = 19'h00050; e.done = 1'b1; e.busy = 1'b0; push("sweep_last_done");
        tick(); e.done = 1'b0; push("done_one_cycle");

        // Negative sweep, rejected sweep_start, then abort with a coincident strobe.
        cfg_sweep_step = 19'h7FFF0; cfg_sweep_count = 16'd5;
        sweep_start = 1'b1; tick(); sweep_start = 1'b0; e.busy = 1'b1; push("sweep2_start");
        ce_down = 1'b1; tick(); ce_down = 1'b0; e.down = 19'h00040; push("sweep_neg1");
        ce_down = 1'b1; tick(); ce_down = 1'b0; e.down = 19'h00030; push("sweep_neg2");
        sweep_start = 1'b1; tick(); sweep_start = 1'b0; e.err = 1'b1; push("start_in_sweep");
        tick(); e.err = 1'b0; push("err_fall_sweep");
        abort = 1'b1; ce_down = 1'b1; tick(); abort = 1'b0;
        e.busy = 1'b0; push("abort_frozen");
        repeat (3) tick();
        ce_down = 1'b0; tick();

        // Zero-length sweep.
        cfg_sweep_count = '0;
        sweep_start = 1'b1; tick(); sweep_start = 1'b0; e.done = 1'b1; push("zero_sweep_done");
        tick(); e.done = 1'b0; push("zero_sweep_fall");

        // commit + sweep_start + ce_down together in idle.
        cfg_phase_inc_nco = 19'h00789; cfg_phase_inc_down = 19'h00030;
        cfg_input_select = 1'b0; cfg_output_select = 2'b11;
        commit = 1'b1; sweep_start = 1'b1; ce_down = 1'b1; tick();
        commit = 1'b0; sweep_start = 1'b0; ce_down = 1'b0;
        e.busy = 1'b1; e.err = 1'b1; push("triple_request");
        tick(); e.err = 1'b0; push("triple_err_fall");
        ce_down = 1'b1; tick(); ce_down = 1'b0;
        e.nco = 19'h00789; e.isel = 1'b0; e.osel = 2'b11; e.busy = 1'b0; push("triple_apply");

        // Recapture in armed; sweep_start rejected while armed.
        cfg_phase_inc_nco = 19'h00111;
        commit = 1'b1; tick(); commit = 1'b0; e.busy = 1'b1; push("armed_commit");
        sweep_start = 1'b1; tick(); sweep_start = 1'b0; e.err = 1'b1; push("start_in_armed");
        cfg_phase_inc_nco = 19'h00222;
        commit = 1'b1; tick(); commit = 1'b0; e.err = 1'b0; push("recapture");
        ce_down = 1'b1; tick(); ce_down = 1'b0;
        e.nco = 19'h00222; e.busy = 1'b0; push("last_write_wins");

        // Abort while armed discards the shadow.
        cfg_phase_inc_nco = 19'h00333;
        commit = 1'b1; tick(); commit = 1'b0; e.busy = 1'b1; push("armed_for_abort");
        abort = 1'b1; tick(); abort = 1'b0; e.busy = 1'b0; push("abort_armed");
        ce_down = 1'b1; tick(); ce_down = 1'b0;
        tick();

        // Large steps: clamp to full scale and to zero.
        cfg_phase_inc_nco = 19'h00222; cfg_gain1 = 32'hFFFF_FFFF; cfg_gain2 = 32'h0000_0000;
        cfg_gain_step = 32'h8000_0000;
        commit = 1'b1; tick(); commit = 1'b0; e.busy = 1'b1; push("clamp_commit");
        ce_down = 1'b1; tick();
        tick(); e.g1 = 32'hC000_0A00; e.g2 = 32'h0000_0000; push("clamp_step1");
        tick(); ce_down = 1'b0;
        e.g1 = 32'hFFFF_FFFF; e.busy = 1'b0; push("clamp_full_scale");

        // Reset mid-operation wins over a concurrent commit.
        commit = 1'b1; tick(); commit = 1'b0; e.busy = 1'b1; push("pre_reset_commit");
        rst = 1'b1; commit = 1'b1; tick(); rst = 1'b0; commit = 1'b0;
        set_reset_expect(); push("mid_reset");
        repeat (5) tick();

        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL pending_expectations: got %0d outstanding, required 0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsp_cfg_scheduler.md
# dsp_cfg_scheduler

Run-time configuration scheduler for the CORDIC down/up-conversion datapath. It holds CSR-written settings in shadow registers and commits them atomically on the downsampler output strobe (`ce_down`), so the datapath never sees a half-applied setting. Gain changes ramp linearly toward their target instead of stepping. It also runs a linear frequency sweep of the downconversion phase increment. It sits between the LiteX CSR bank and the NCO/mixer/gain inputs of the converter core.

## Interface
Parameters:
- `PW`, 19, phase-increment width.
- `GW`, 32, gain width; unsigned, unity = 2^30.
- `CW`, 16, sweep step-count width.
- `GAIN_RST`, 32'h4000_0000, reset value of both gains (unity).

Ports:
- `sys_clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `cfg_phase_inc_nco` in PW: shadow NCO increment.
- `cfg_phase_inc_down` in PW: shadow downconversion increment.
- `cfg_gain1`, `cfg_gain2` in GW: target gains.
- `cfg_gain_step` in GW: ramp step per strobe; 0 means apply immediately.
- `cfg_input_select` in 1 and `cfg_output_select` in 2: shadow mux selects.
- `cfg_sweep_step` in PW: signed per-strobe increment delta.
- `cfg_sweep_count` in CW: number of sweep steps.
- `commit` in 1: single-cycle request to apply the shadow config.
- `sweep_start` in 1: single-cycle request to start a sweep.
- `abort` in 1: single-cycle request to stop any operation.
- `ce_down` in 1: downsampler output strobe; the only apply point.
- `phase_inc_nco`, `phase_inc_down` out PW: live increments.
- `gain1`, `gain2` out GW: live gains.
- `input_select` out 1 and `output_select` out 2: live selects.
- `busy` out 1: high whenever state ≠ IDLE.
- `sweep_done` out 1: single-cycle pulse when a sweep ends.
- `cmd_err` out 1: single-cycle pulse when a request is rejected.

## Operation
- States: IDLE, ARMED, RAMP, SWEEP.
- IDLE + `commit`: capture all `cfg_*` except the sweep fields into shadow; go to ARMED.
- ARMED + `commit`: re-capture the shadow (last write wins); stay in ARMED.
- ARMED + `ce_down`: apply both increments and both selects.
  - If the captured gain step is 0, also load both gains directly and go to IDLE.
  - Otherwise go to RAMP.
- RAMP, on each `ce_down`, for each gain independently:
  - if |target − live| ≤ step: live = target;
  - else live moves toward target by step.
  - When both gains equal their targets after an update, go to IDLE.
- IDLE + `sweep_start`: capture step and count.
  - count = 0: pulse `sweep_done` on the next cycle and stay in IDLE; no output change.
  - Otherwise go to SWEEP.
- SWEEP, on each `ce_down`: `phase_inc_down` += step (mod 2^PW, wraps silently); count −1.
  - When count reaches 0, pulse `sweep_done` in the same cycle the last increment appears, then go to IDLE.
- Rejected requests (pulse `cmd_err`, no state change):
  - `commit` or `sweep_start` while in RAMP or SWEEP;
  - `sweep_start` while in ARMED.
- Same-cycle priority: `abort` > `commit` > `sweep_start`.
  - In IDLE, `commit` + `sweep_start` → commit is accepted and `cmd_err` pulses.
- `abort`, any state: go to IDLE the next cycle.
  - All live outputs hold their current values.
  - The shadow is discarded.
  - `sweep_done` is not pulsed.
- A `ce_down` in the same cycle as an accepted `commit` does not apply; the first eligible strobe is the next one.
- Gain arithmetic: compute with one guard bit (GW+1) so a step never over- or under-flows. Live gain stays in [0, 2^GW−1].

## Timing
- Reset values:
  - `phase_inc_nco` = 0 and `phase_inc_down` = 0;
  - `gain1` = `gain2` = GAIN_RST;
  - `input_select` = 0 and `output_select` = 0;
  - `busy`, `sweep_done`, `cmd_err` = 0;
  - state = IDLE.
- `rst` mid-operation forces the reset values on the next edge, regardless of other inputs.
- All outputs are registered.
- A setting applied on `ce_down` at cycle N is visible at cycle N+1.
- `busy` rises the cycle after an accepted request.
- `busy` falls the cycle after the final apply, or the cycle after `abort`.
- `cmd_err` and `sweep_done` are exactly one cycle wide.
- Requests are level-sampled each cycle. A request held high is treated as repeated requests: once busy, it pulses `cmd_err` each cycle.

## Structure
- Shared package `dsp_cfg_pkg`: state enum; `GAIN_UNITY` = 32'h4000_0000; the output_select encodings (00 downsampled, 01 upsampled, 10 downconverted, 11 upconverted).
- One sub-module `gain_ramp_step`: combinational next value plus a "reached" flag for one gain channel; instantiated twice.
- The FSM and sweep counter live in the top module.

## Test plan
- Reset, then idle 10 cycles → gains = 0x4000_0000, increments 0, `busy` = 0.
- `commit` with `cfg_phase_inc_down` = 0x1000, `cfg_gain_step` = 0, `ce_down` 5 cycles later → outputs unchanged until that strobe, new values one cycle after; `busy` high for exactly 5 cycles.
- Gain 0x4000_0000 → 0x4000_0A00 with step 0x400 → values 0x...400, 0x...800, 0x...A00 on three successive strobes, then IDLE.
- Sweep from 0x7FFF0, step 0x20, count 3 → 0x00010, 0x00030, 0x00050 (wrap); `sweep_done` coincides with 0x00050.
- `commit` during RAMP, then `abort` mid-sweep → `cmd_err` pulse with no change; after abort, outputs frozen, IDLE next cycle, no `sweep_done`.
- `commit` + `sweep_start` + `ce_down` in the same cycle in IDLE → ARMED, `cmd_err` pulse, no apply until the next `ce_down`.
